// File: rtl/bist_controller.sv
// bist_controller: sequencing FSM for the adder BIST datapath.
// Loads the TPG, steps PAT_CNT patterns while the MISR compacts the CUT
// responses, flushes the CUT output register, then latches the final
// signature on Result and compares it against GOLDEN_SIG.
// Optional feature macro: BIST_INTERVAL_SIG_EN (intermediate signature
// capture every INTERVAL patterns, marked by a one-cycle sig_strobe pulse).
// All outputs are registered; reset is asynchronous and active-low.

module bist_controller #(
    parameter int               SIG_W      = 10,
    parameter int               PAT_CNT    = 255,
    parameter int               CNT_W      = 8,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 10'h000,
    parameter int               INTERVAL   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             tpg_load,
    output logic             tpg_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic [CNT_W-1:0] pat_idx,
    output logic [SIG_W-1:0] Result,
    output logic             Ready,
    output logic             pass,
    output logic             sig_strobe
);

    // Index of the last pattern of a run; pat_idx never reaches PAT_CNT.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAT_CNT - 1);
    localparam logic [CNT_W-1:0] INT_LEN  = CNT_W'(INTERVAL);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INTERVAL - 1);

`ifdef BIST_INTERVAL_SIG_EN
    localparam bit INTERVAL_EN = 1'b1;
`else
    localparam bit INTERVAL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               tpg_load_nxt;
    logic               tpg_en_nxt;
    logic               misr_clr_nxt;
    logic               misr_en_nxt;
    logic [CNT_W-1:0]   pat_idx_nxt;
    logic [SIG_W-1:0]   result_nxt;
    logic               ready_nxt;
    logic               pass_nxt;
    logic               strobe_nxt;
    logic               interval_hit;

    // The pattern being applied closes an interval; constant-false when the
    // intermediate capture feature is not built in.
    assign interval_hit = INTERVAL_EN && ((pat_idx % INT_LEN) == INT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next registered outputs; outputs are computed for the
    // state being entered so every strobe lines up with its state.
    always_comb begin
        state_nxt    = state;
        tpg_load_nxt = 1'b0;
        tpg_en_nxt   = 1'b0;
        misr_clr_nxt = 1'b0;
        misr_en_nxt  = 1'b0;
        pat_idx_nxt  = pat_idx;
        result_nxt   = Result;
        pass_nxt     = pass;
        ready_nxt    = 1'b0;
        strobe_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (valid) begin
                    state_nxt    = LOAD;
                    tpg_load_nxt = 1'b1;
                    misr_clr_nxt = 1'b1;
                    pat_idx_nxt  = '0;
                    result_nxt   = '0;
                    pass_nxt     = 1'b0;
                end
            end

            LOAD: begin
                if (!valid) begin
                    state_nxt  = IDLE;
                    result_nxt = '0;
                    pass_nxt   = 1'b0;
                end else begin
                    state_nxt   = RUN;
                    tpg_en_nxt  = 1'b1;
                    misr_en_nxt = 1'b1;
                    pat_idx_nxt = '0;
                end
            end

            RUN: begin
                if (!valid) begin
                    // An abort discards any intermediate capture as well.
                    state_nxt  = IDLE;
                    result_nxt = '0;
                    pass_nxt   = 1'b0;
                end else begin
                    if (interval_hit) begin
                        result_nxt = misr_sig;
                        strobe_nxt = 1'b1;
                    end
                    if (pat_idx == LAST_IDX) begin
                        // Stop the TPG but keep compacting for one more cycle
                        // to pick up the response still in the CUT register.
                        state_nxt   = FLUSH;
                        misr_en_nxt = 1'b1;
                    end else begin
                        tpg_en_nxt  = 1'b1;
                        misr_en_nxt = 1'b1;
                        pat_idx_nxt = pat_idx + 1'b1;
                    end
                end
            end

            FLUSH: begin
                if (!valid) begin
                    state_nxt  = IDLE;
                    result_nxt = '0;
                    pass_nxt   = 1'b0;
                end else begin
                    state_nxt = CHECK;
                end
            end

            CHECK: begin
                if (!valid) begin
                    state_nxt  = IDLE;
                    result_nxt = '0;
                    pass_nxt   = 1'b0;
                end else begin
                    state_nxt  = DONE;
                    result_nxt = misr_sig;
                    pass_nxt   = (misr_sig == GOLDEN_SIG);
                    ready_nxt  = 1'b1;
                end
            end

            DONE: begin
                // A held request does not retrigger; it must drop first.
                if (!valid) begin
                    state_nxt = IDLE;
                end else begin
                    ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpg_load   <= 1'b0;
            tpg_en     <= 1'b0;
            misr_clr   <= 1'b0;
            misr_en    <= 1'b0;
            pat_idx    <= '0;
            Result     <= '0;
            Ready      <= 1'b0;
            pass       <= 1'b0;
            sig_strobe <= 1'b0;
        end else begin
            tpg_load   <= tpg_load_nxt;
            tpg_en     <= tpg_en_nxt;
            misr_clr   <= misr_clr_nxt;
            misr_en    <= misr_en_nxt;
            pat_idx    <= pat_idx_nxt;
            Result     <= result_nxt;
            Ready      <= ready_nxt;
            pass       <= pass_nxt;
            sig_strobe <= strobe_nxt;
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: directed bench for bist_controller.
// Instance a: PAT_CNT=8, GOLDEN_SIG=10'h1A5. Instance b: PAT_CNT=32,
// INTERVAL=16, used for the intermediate-capture behaviour.
// Each MISR is modelled as base + (number of compaction cycles since clear),
// so the final signature is base + PAT_CNT + 1.

module tb_bist_controller;

    logic       clk;
    logic       rst_n;

    logic       valid_a;
    logic [9:0] misr_a;
    logic       tpg_load_a, tpg_en_a, misr_clr_a, misr_en_a;
    logic [7:0] pat_idx_a;
    logic [9:0] result_a;
    logic       ready_a, pass_a, sig_strobe_a;

    logic       valid_b;
    logic [9:0] misr_b;
    logic       tpg_load_b, tpg_en_b, misr_clr_b, misr_en_b;
    logic [7:0] pat_idx_b;
    logic [9:0] result_b;
    logic       ready_b, pass_b, sig_strobe_b;

    logic [9:0] base_a, cnt_a;
    logic [9:0] base_b, cnt_b;

    int n_tests;
    int n_fail;

    bist_controller #(
        .SIG_W(10), .PAT_CNT(8), .CNT_W(8), .GOLDEN_SIG(10'h1A5), .INTERVAL(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .valid(valid_a), .misr_sig(misr_a),
        .tpg_load(tpg_load_a), .tpg_en(tpg_en_a), .misr_clr(misr_clr_a),
        .misr_en(misr_en_a), .pat_idx(pat_idx_a), .Result(result_a),
        .Ready(ready_a), .pass(pass_a), .sig_strobe(sig_strobe_a)
    );

    bist_controller #(
        .SIG_W(10), .PAT_CNT(32), .CNT_W(8), .GOLDEN_SIG(10'h000), .INTERVAL(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .valid(valid_b), .misr_sig(misr_b),
        .tpg_load(tpg_load_b), .tpg_en(tpg_en_b), .misr_clr(misr_clr_b),
        .misr_en(misr_en_b), .pat_idx(pat_idx_b), .Result(result_b),
        .Ready(ready_b), .pass(pass_b), .sig_strobe(sig_strobe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign misr_a = base_a + cnt_a;
    assign misr_b = base_b + cnt_b;

    // MISR stand-ins: count compaction cycles since the last clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (misr_clr_a)     cnt_a <= '0;
            else if (misr_en_a) cnt_a <= cnt_a + 10'd1;
            if (misr_clr_b)     cnt_b <= '0;
            else if (misr_en_b) cnt_b <= cnt_b + 10'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run on instance a ending with the MISR at sig; leaves it in DONE.
    task automatic run_a(input logic [9:0] sig, input logic exp_pass, input string nm);
        int en_cnt;
        en_cnt  = 0;
        base_a  = sig - 10'd9;
        valid_a = 1'b1;
        tick();                                   // edge 0 -> LOAD
        en_cnt += int'(tpg_en_a);
        check({nm, "_load"},    32'(tpg_load_a), 32'd1);
        check({nm, "_clr"},     32'(misr_clr_a), 32'd1);
        check({nm, "_idx0"},    32'(pat_idx_a),  32'd0);
        check({nm, "_res_clr"}, 32'(result_a),   32'd0);
        check({nm, "_rdy_clr"}, 32'(ready_a),    32'd0);
        for (int k = 1; k <= 8; k++) begin        // edges 1..8 -> RUN
            tick();
            en_cnt += int'(tpg_en_a);
            check({nm, "_run_idx"}, 32'(pat_idx_a), 32'(k - 1));
            check({nm, "_run_men"}, 32'(misr_en_a), 32'd1);
        end
        tick();                                   // edge 9 -> FLUSH
        en_cnt += int'(tpg_en_a);
        check({nm, "_flush_ten"}, 32'(tpg_en_a),  32'd0);
        check({nm, "_flush_men"}, 32'(misr_en_a), 32'd1);
        tick();                                   // edge 10 -> CHECK
        en_cnt += int'(tpg_en_a);
        check({nm, "_chk_rdy"}, 32'(ready_a), 32'd0);
        tick();                                   // edge 11 -> DONE
        en_cnt += int'(tpg_en_a);
        check({nm, "_ready"},  32'(ready_a),      32'd1);
        check({nm, "_result"}, 32'(result_a),     32'(sig));
        check({nm, "_pass"},   32'(pass_a),       32'(exp_pass));
        check({nm, "_en_cnt"}, 32'(en_cnt),       32'd8);
        check({nm, "_strobe"}, 32'(sig_strobe_a), 32'd0);
    endtask

    initial begin
        int loads;
        int n;
        int strobes;
        int leak;
        logic [9:0] cap [2];

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        base_a  = '0;
        base_b  = 10'h200;
        cap[0]  = '0;
        cap[1]  = '0;

        // Reset state, before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_tpg_load", 32'(tpg_load_a), 32'd0);
        check("rst_tpg_en",   32'(tpg_en_a),   32'd0);
        check("rst_misr_en",  32'(misr_en_a),  32'd0);
        check("rst_pat_idx",  32'(pat_idx_a),  32'd0);
        check("rst_result",   32'(result_a),   32'd0);
        check("rst_ready",    32'(ready_a),    32'd0);
        check("rst_pass",     32'(pass_a),     32'd0);
        check("rst_strobe",   32'(sig_strobe_b), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_no_load", 32'(tpg_load_a), 32'd0);

        // Nominal run, then hold valid in DONE for 5 cycles.
        run_a(10'h1A5, 1'b1, "nom");
        loads = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            loads += int'(tpg_load_a);
            check("hold_ready", 32'(ready_a), 32'd1);
        end
        check("hold_no_load", 32'(loads), 32'd0);
        valid_a = 1'b0;
        tick();
        check("rel_ready",  32'(ready_a),  32'd0);
        check("rel_result", 32'(result_a), 32'h1A5);
        check("rel_pass",   32'(pass_a),   32'd1);
        tick();

        // Signature mismatch.
        run_a(10'h1A4, 1'b0, "mis");
        valid_a = 1'b0;
        tick();
        check("mis_rel_ready", 32'(ready_a), 32'd0);

        // Abort while pat_idx = 3.
        valid_a = 1'b1;
        tick();                                   // LOAD
        for (int i = 0; i < 4; i++) tick();       // RUN, pat_idx 0..3
        check("abt_idx3", 32'(pat_idx_a), 32'd3);
        valid_a = 1'b0;
        tick();
        check("abt_tpg_en",   32'(tpg_en_a),   32'd0);
        check("abt_misr_en",  32'(misr_en_a),  32'd0);
        check("abt_tpg_load", 32'(tpg_load_a), 32'd0);
        check("abt_misr_clr", 32'(misr_clr_a), 32'd0);
        check("abt_ready",    32'(ready_a),    32'd0);
        check("abt_result",   32'(result_a),   32'd0);
        check("abt_pass",     32'(pass_a),     32'd0);
        tick();
        check("abt_idle", 32'(tpg_load_a), 32'd0);
        valid_a = 1'b1;
        tick();
        check("restart_load", 32'(tpg_load_a), 32'd1);
        check("restart_idx",  32'(pat_idx_a),  32'd0);

        // Asynchronous reset mid-run, between clock edges.
        for (int i = 0; i < 3; i++) tick();       // RUN, pat_idx 2
        check("pre_rst_idx", 32'(pat_idx_a), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_tpg_en",  32'(tpg_en_a),  32'd0);
        check("arst_misr_en", 32'(misr_en_a), 32'd0);
        check("arst_pat_idx", 32'(pat_idx_a), 32'd0);
        check("arst_result",  32'(result_a),  32'd0);
        check("arst_ready",   32'(ready_a),   32'd0);
        valid_a = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("arst_idle", 32'(tpg_load_a), 32'd0);

        // Interval capture on instance b (PAT_CNT=32, INTERVAL=16).
        valid_b = 1'b1;
        tick();                                   // edge 0 -> LOAD
        n       = 0;
        strobes = 0;
        leak    = 0;
        while (!ready_b && n < 60) begin
            tick();
            n++;
            if (sig_strobe_b) begin
                if (strobes < 2) cap[strobes] = result_b;
                strobes++;
            end
            if (!ready_b && result_b != 10'h000) leak++;
        end
        check("b_ready",  32'(ready_b),  32'd1);
        check("b_cycles", 32'(n),        32'd35);
        check("b_result", 32'(result_b), 32'h221);
        check("b_pass",   32'(pass_b),   32'd0);
`ifdef BIST_INTERVAL_SIG_EN
        check("b_strobes", 32'(strobes), 32'd2);
        check("b_cap15",   32'(cap[0]),  32'h20F);
        check("b_cap31",   32'(cap[1]),  32'h21F);
`else
        check("b_strobes", 32'(strobes), 32'd0);
        check("b_no_mid",  32'(leak),    32'd0);
`endif
        valid_b = 1'b0;
        tick();
        check("b_rel_ready", 32'(ready_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencing controller for the adder BIST datapath. On a `valid` request it loads the test-pattern generator (TPG), steps it for a fixed number of patterns while the MISR compacts CUT responses, then latches the final signature on `Result`. It compares that signature against a golden value and raises `Ready`. It sits inside `top`, between the external handshake and the TPG/CUT/MISR datapath.

## Interface
- `SIG_W`, 10: signature width (MISR and `Result`).
- `PAT_CNT`, 255: patterns applied per run; legal range is 1..2^CNT_W-1.
- `CNT_W`, 8: pattern counter width.
- `GOLDEN_SIG`, 10'h000: expected final signature.
- `INTERVAL`, 16: interval, in patterns, between intermediate signature captures (used only when the macro is enabled).

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid` in 1: level-sensitive run request; must stay high for the whole run.
- `misr_sig` in SIG_W: current MISR contents.
- `tpg_load` out 1: loads the TPG seed.
- `tpg_en` out 1: advances the TPG by one pattern.
- `misr_clr` out 1: clears the MISR.
- `misr_en` out 1: compacts the CUT output into the MISR.
- `pat_idx` out CNT_W: index of the pattern currently applied.
- `Result` out SIG_W: latched signature.
- `Ready` out 1: run complete.
- `pass` out 1: final signature equals `GOLDEN_SIG`.
- `sig_strobe` out 1: one-cycle pulse marking an intermediate signature capture.

## Operation
- FSM states: IDLE, LOAD, RUN, FLUSH, CHECK, DONE. All outputs are registered.
- Reset (asynchronous, `rst_n`=0): state goes to IDLE and every output is driven to 0, including `Result`, `pass`, `pat_idx` and `sig_strobe`.
- IDLE: all strobes are 0. If `valid`=1 at a clock edge, go to LOAD.
- LOAD (1 cycle):
  - `tpg_load`=1 and `misr_clr`=1.
  - `pat_idx`=0; `Result`, `pass` and `Ready` are cleared.
  - Next state is RUN.
- RUN (PAT_CNT cycles):
  - `tpg_en`=1 and `misr_en`=1.
  - `pat_idx` increments each cycle, taking values 0..PAT_CNT-1.
  - After the cycle with `pat_idx`=PAT_CNT-1, go to FLUSH.
- FLUSH (1 cycle): `tpg_en`=0, `misr_en`=1. This absorbs the one-cycle CUT output register latency so the last response is compacted.
- CHECK (1 cycle):
  - `Result` <= `misr_sig`.
  - `pass` <= (`misr_sig` == `GOLDEN_SIG`).
  - Next state is DONE.
- DONE: `Ready`=1 and all strobes are 0. `Result` and `pass` are held. When `valid`=0, go to IDLE and clear `Ready`; `Result` and `pass` keep their values until the next LOAD.
- Abort: `valid`=0 in LOAD, RUN, FLUSH or CHECK means the next state is IDLE. In that case all strobes are 0, `Ready` stays 0, and `Result`/`pass` are left at their LOAD-cleared value of 0.
- `valid` held high in DONE does not restart a run; it must be deasserted before a new request is accepted.
- Arithmetic: `pat_idx` is unsigned CNT_W bits and never wraps, because PAT_CNT < 2^CNT_W.

## Timing
- Edge 0 samples `valid`=1 in IDLE.
- LOAD strobes are active in the cycle after edge 0.
- RUN spans edges 1..PAT_CNT, FLUSH follows at edge PAT_CNT+1, and CHECK at edge PAT_CNT+2.
- `Ready` and the final `Result`/`pass` become visible after edge PAT_CNT+3.
- `Ready` falls one edge after `valid` is sampled low in DONE.
- Abort takes effect on the first edge that samples `valid`=0; the strobes drop in that same update.
- Asynchronous reset acts immediately, with no clock needed.

## Configuration
- Macro: `BIST_INTERVAL_SIG_EN`.
- Defined:
  - In RUN, on each edge where `pat_idx` % INTERVAL == INTERVAL-1, `Result` <= `misr_sig` and `sig_strobe` pulses high for exactly one cycle.
  - The final CHECK capture still overwrites `Result`.
  - `pass` is evaluated only in CHECK.
- Not defined: `sig_strobe` is tied to 0, and `Result` changes only in LOAD (clear) and CHECK.

## Test plan
- Nominal run:
  - Stimulus: PAT_CNT=8, GOLDEN_SIG=10'h1A5, a MISR model that ends at 10'h1A5, `valid` held high.
  - Required: `tpg_en` high for exactly 8 cycles and `pat_idx` steps 0..7; `Ready`=1 after edge 11; `Result`=10'h1A5 and `pass`=1.
- Mismatch:
  - Stimulus: as the nominal run, but the MISR model ends at 10'h1A4.
  - Required: `Ready`=1, `Result`=10'h1A4, `pass`=0.
- Abort mid-run:
  - Stimulus: drop `valid` while `pat_idx`=3.
  - Required: next cycle the FSM is in IDLE with all strobes 0, `Ready`=0 and `Result`=0; a later `valid` rise starts a fresh LOAD with `pat_idx`=0.
- Asynchronous reset mid-run:
  - Stimulus: pulse `rst_n` low between clock edges during RUN.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge.
- Handshake hold:
  - Stimulus: keep `valid` high for 5 cycles in DONE, then release it.
  - Required: no new LOAD occurs; `Ready` falls one edge after the release; `Result` is retained.
- Interval capture, with `BIST_INTERVAL_SIG_EN` defined:
  - Stimulus: PAT_CNT=32, INTERVAL=16.
  - Required: `sig_strobe` pulses exactly twice, at `pat_idx`=15 and `pat_idx`=31, each time showing the sampled `misr_sig` on `Result`. Without the macro, `sig_strobe` stays 0.
